// File: rtl/fetch_decode_fsm.sv
// Top-level instruction sequencer: fetches a program word, latches it into the IR,
// decodes the class field and hands control to exactly one execution FSM.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, all outputs low
// FETCH  | PC on address bus, memory read issued
// LATCH  | memory data valid, IR loads at the closing edge
// DECODE | class field decoded; illegal classes pulse pcInc
// EXEC   | one unit enabled, watchdog counting until its done
// HALT   | stopped by a halt instruction, start resumes fetching
// FAULT  | watchdog expired, sticky until rst
module fetch_decode_fsm #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] memData,
   input  logic [5:0]  unitDone,
   output logic        memRead,
   output logic        pcOutEN,
   output logic        irLatch,
   output logic [15:0] instruction,
   output logic [5:0]  unitEN,
   output logic        pcInc,
   output logic        halted,
   output logic        fault
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LATCH  = 3'd2,
      DECODE = 3'd3,
      EXEC   = 3'd4,
      HALT   = 3'd5,
      FAULT  = 3'd6
   } state_t;

   localparam logic [7:0] WDOG_TC = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] wdog_cnt;
   logic [3:0] cls;
   logic       cls_legal;
   logic       cls_halt;
   logic       unit_done;

   assign cls       = instruction[15:12];
   assign cls_legal = (cls <= 4'd5);
   assign cls_halt  = (cls == 4'hF);
   // unitEN is one-hot, so masking selects the active unit's done only
   assign unit_done = |(unitDone & unitEN);

   assign memRead = (state == FETCH) || (state == LATCH);
   assign pcOutEN = (state == FETCH) || (state == LATCH);
   assign irLatch = (state == LATCH);
   assign pcInc   = (state == DECODE) && !cls_legal && !cls_halt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         instruction <= 16'h0000;
         unitEN      <= 6'b000000;
         wdog_cnt    <= 8'd0;
         halted      <= 1'b0;
         fault       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) state <= FETCH;
            end
            FETCH: begin
               state <= LATCH;
            end
            LATCH: begin
               instruction <= memData;
               state       <= DECODE;
            end
            DECODE: begin
               if (cls_legal) begin
                  unitEN   <= 6'b000001 << cls;
                  wdog_cnt <= 8'd0;
                  state    <= EXEC;
               end else if (cls_halt) begin
                  halted <= 1'b1;
                  state  <= HALT;
               end else begin
                  state <= FETCH;
               end
            end
            EXEC: begin
               // done wins over a watchdog expiry in the same cycle
               if (unit_done) begin
                  unitEN <= 6'b000000;
                  state  <= FETCH;
               end else if (wdog_cnt == WDOG_TC) begin
                  unitEN <= 6'b000000;
                  fault  <= 1'b1;
                  state  <= FAULT;
               end else begin
                  wdog_cnt <= wdog_cnt + 8'd1;
               end
            end
            HALT: begin
               if (start) begin
                  halted <= 1'b0;
                  state  <= FETCH;
               end
            end
            FAULT: begin
               unitEN <= 6'b000000;
               fault  <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_decode_fsm.md
# fetch_decode_fsm

Top-level instruction sequencer of the microcontroller, sitting directly upstream of the execution FSMs (ALU-immediate, ALU-register, load, store, move, jump). Fetches a 16-bit word from program memory, latches it into the instruction register, decodes the class field, and enables exactly one execution FSM until it reports done. Also handles halt, illegal opcodes, and a watchdog that faults on a hung execution FSM.

## Interface
- TIMEOUT, 255: EXEC cycles allowed without unit done before FAULT; legal range 1..255.

- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  leaves IDLE, or resumes from HALT; ignored in all other states.
- memData  in  16  program-memory read data, valid during LATCH.
- unitDone  in  6  done flags from execution FSMs; bit order matches unitEN.
- memRead  out  1  program-memory read strobe.
- pcOutEN  out  1  drives PC onto the memory address bus.
- irLatch  out  1  instruction-register load strobe, for observability.
- instruction  out  16  instruction-register contents, broadcast to all execution FSMs.
- unitEN  out  6  one-hot execution enable: [0] ALU-imm, [1] ALU-reg, [2] load, [3] store, [4] move, [5] jump.
- pcInc  out  1  PC increment pulse, used only for skipped illegal opcodes.
- halted  out  1  high while in HALT.
- fault  out  1  high while in FAULT.

## Operation
- States: IDLE, FETCH, LATCH, DECODE, EXEC, HALT, FAULT.
- IDLE: all outputs 0. On start=1, go to FETCH.
- FETCH: memRead=1, pcOutEN=1. Next state is LATCH.
- LATCH: memRead=1, pcOutEN=1, irLatch=1. The IR loads memData at the closing edge. Next state is DECODE.
- DECODE: classify instruction[15:12].
  - 0x0..0x5: go to EXEC. Load unitEN with the one-hot bit for that class and clear the watchdog counter.
  - 0xF: go to HALT.
  - 0x6..0xE (illegal): pcInc=1 for this cycle only, then go to FETCH.
- EXEC: unitEN holds its one-hot value. Only unitDone[selected] is sampled; other done bits are ignored.
  - Done=1: go to FETCH and clear unitEN.
  - Done=0 and counter==TIMEOUT-1: go to FAULT and clear unitEN.
  - Done=0 otherwise: increment the 8-bit counter.
  - Done takes priority over timeout in the same cycle.
- HALT: halted=1, memRead=0. On start=1, go to FETCH.
- FAULT: fault=1, unitEN=0. Sticky; only rst exits.
- Execution FSMs own PC increment for legal instructions. This block never increments PC for them.
- The IR changes only in LATCH and holds its value in every other state.
- unitEN, halted and fault are registered outputs. memRead, pcOutEN, irLatch and pcInc are decoded from state.
- unitEN is never more than one-hot.

## Timing
- Reset (async, immediate): state=IDLE, instruction=16'h0000, counter=0, all outputs 0.
- Reset mid-EXEC drops unitEN in the same cycle, with no clock edge required.
- Cycle numbering, with start sampled at edge 0:
  - FETCH: cycle 1.
  - LATCH: cycle 2.
  - DECODE: cycle 3; instruction valid from here.
  - EXEC: cycle 4; unitEN asserted.
- Minimum instruction period is 4 cycles, when done arrives in the first EXEC cycle.
- A unit done in EXEC cycle k puts the block in FETCH in cycle k+1, with unitEN=0 in that same cycle.
- FAULT is entered after exactly TIMEOUT consecutive EXEC cycles without done.
- A done in the TIMEOUT-th cycle completes normally.
- start during FETCH, LATCH, DECODE, EXEC or FAULT has no effect.

## Test plan
- Reset, start pulse, memData=16'h0044 (ALU-imm Add R1 4):
  - memRead/pcOutEN high in cycles 1-2.
  - instruction=16'h0044 from cycle 3.
  - unitEN=6'b000001 from cycle 4.
  - unitDone[0] raised in EXEC cycle 3 → unitEN=0 and FETCH on the next cycle.
- memData=16'h5010 (jump): unitEN=6'b100000. unitDone[0]=1 held throughout is ignored. unitDone[5] ends EXEC.
- memData=16'h9ABC (illegal): pcInc=1 for exactly one cycle in DECODE, unitEN stays 0, next state is FETCH.
- memData=16'hF000: halted=1 and memRead stays 0 for 20 cycles. A start pulse clears halted and gives memRead=1 on the next cycle.
- TIMEOUT=4:
  - No done → fault=1 after 4 EXEC cycles, unitEN=0, fault still 1 ten cycles later.
  - Repeat with unitDone asserted in EXEC cycle 4 → fault stays 0.
- rst asserted between clock edges during EXEC: unitEN, instruction and all strobes read 0 before the next edge. After rst is released, the block stays in IDLE until start.
